// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester arbiters: requester count, index type
// and the post-reset pointer that gives requester 0 first priority.
package arb_pkg;
    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] reqIdx_t;

    // "Last granted" starts at 3 so the round-robin search begins at 0.
    localparam reqIdx_t RESET_PTR = 2'd3;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first valid requester after ptr, searching
// ptr+1, ptr+2, ptr+3 and finally ptr itself (all mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req_valid,
    input  reqIdx_t         ptr,
    output logic            any,
    output reqIdx_t         idx
);
    reqIdx_t cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        // Offset NREQ wraps to ptr, so the last granted requester is tried last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = ptr + reqIdx_t'(k);
            if (!any && req_valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/yMux4to1.sv
// Parameterised 4:1 datapath mux; sel picks which of a0..a3 drives z.
module yMux4to1 #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] a2,
    input  logic [SIZE-1:0] a3,
    input  logic [1:0]      sel,
    output logic [SIZE-1:0] z
);
    always_comb begin
        unique case (sel)
            2'd0:    z = a0;
            2'd1:    z = a1;
            2'd2:    z = a2;
            default: z = a3;
        endcase
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded burst lock in front of a 4:1 mux; the winning
// word is captured into a single-entry output register.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_lock,
    input  logic [SIZE-1:0] req_data0,
    input  logic [SIZE-1:0] req_data1,
    input  logic [SIZE-1:0] req_data2,
    input  logic [SIZE-1:0] req_data3,
    output logic [NREQ-1:0] req_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic [IDX_W-1:0] out_src,
    input  logic            out_ready
);
    // Handshakes: a word moves when valid & ready are both high at a rising edge.
    // A source raises valid independently of ready and holds valid and data
    // unchanged until that edge; ready may depend combinationally on valid.

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST - 1);

    reqIdx_t          ptr;
    logic [CNT_W-1:0] burstCnt;

    logic             space;
    logic             rrAny;
    reqIdx_t          rrIdx;
    logic             lockHit;
    reqIdx_t          winner;
    logic             accept;
    logic [SIZE-1:0]  muxData;

    rr_pick4 picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .any       (rrAny),
        .idx       (rrIdx)
    );

    yMux4to1 #(.SIZE(SIZE)) dataMux (
        .a0  (req_data0),
        .a1  (req_data1),
        .a2  (req_data2),
        .a3  (req_data3),
        .sel (winner),
        .z   (muxData)
    );

    // Lock only extends an existing grant, so lockHit implies rrAny.
    assign space   = !out_valid || out_ready;
    assign lockHit = req_valid[ptr] && req_lock[ptr] && (burstCnt < BURST_LIM);
    assign winner  = lockHit ? ptr : rrIdx;
    assign accept  = space && rrAny;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= RESET_PTR;
            burstCnt  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= muxData;
            out_src   <= winner;
            ptr       <= winner;
            burstCnt  <= lockHit ? burstCnt + 1'b1 : '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
